// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: widths, the
// write-buffer entry layout and the access legality check.
package dm_pkg;

  localparam int DATA_W     = 32;
  localparam int WIDX_W     = 30;  // full word index carried by addr[31:2]
  localparam int DEF_ADDR_W = 10;

  typedef struct packed {
    logic [WIDX_W-1:0] index;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Legal: selected, exactly one strobe, word aligned, within 2^addr_w words.
  function automatic logic access_legal(input logic cs, input logic rd,
                                        input logic wr, input logic [31:0] addr,
                                        input int addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return cs && (rd ^ wr) && (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/dm_wbuf.sv
// Posted-store FIFO for dm_responder: push at tail, pop at head, and a
// parallel associative lookup that returns the youngest matching entry.
module dm_wbuf
  import dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head_entry,
  output logic              full,
  output logic              empty,
  input  logic [WIDX_W-1:0] lookup_index,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  wb_entry_t        entries [DEPTH];
  logic             push_ok;
  logic             pop_ok;
  logic [PTR_W-1:0] slot;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == CNT_W'(0));
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign head_entry = entries[head];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_ok) entries[tail] <= push_entry;
  end

  // Scan oldest to youngest so the last valid match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[slot].index == lookup_index)) begin
        hit      = 1'b1;
        hit_data = entries[slot].data;
      end else begin
        hit      = hit;
        hit_data = hit_data;
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word storage, zero-latency reads, sticky error.
// Optional feature macro DM_WBUF_EN: posted write buffer with forwarding,
// idle-port draining and a store stall when the buffer is full. Without it,
// stores write storage directly and dm_ready is constantly 1.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dm_ready,
  output logic        err
);

  localparam int MEM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              legal;
  logic [ADDR_W-1:0] idx;

  assign legal = access_legal(DM_CS, DM_R, DM_W, addr, ADDR_W);
  assign idx   = addr[ADDR_W+1:2];

  // Any selected but illegal access latches the error until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (DM_CS && !legal) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

`ifdef DM_WBUF_EN

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [WIDX_W-1:0] widx;
  logic              port_free;
  wb_entry_t         push_entry;
  wb_entry_t         head_entry;
  logic              unused_idx_hi;

  assign widx       = addr[31:2];
  assign dm_ready   = !(DM_CS && DM_W && full);
  assign push       = legal && DM_W && dm_ready;
  // A stalled store frees the port, otherwise a full buffer could never drain.
  assign port_free  = !(legal && dm_ready);
  assign pop        = port_free && !empty;
  assign push_entry = '{index: widx, data: wdata};
  assign unused_idx_hi = |head_entry.index[WIDX_W-1:ADDR_W];

  dm_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .head_entry   (head_entry),
    .full         (full),
    .empty        (empty),
    .lookup_index (widx),
    .hit          (hit),
    .hit_data     (hit_data)
  );

  // Drain the oldest buffered store whenever the array port is idle.
  always_ff @(posedge clk) begin
    if (pop) mem[head_entry.index[ADDR_W-1:0]] <= head_entry.data;
  end

  // Same-cycle read: buffered data shadows storage.
  always_comb begin
    if (legal && DM_R) begin
      if (hit) rdata = hit_data;
      else     rdata = mem[idx];
    end else begin
      rdata = 32'd0;
    end
  end

`else

  localparam int UNUSED_WB_DEPTH = WB_DEPTH;

  assign dm_ready = 1'b1;

  // Legal stores go straight to storage at the accepting edge.
  always_ff @(posedge clk) begin
    if (legal && DM_W) mem[idx] <= wdata;
  end

  // Same-cycle read straight from storage.
  always_comb begin
    if (legal && DM_R) rdata = mem[idx];
    else               rdata = 32'd0;
  end

`endif

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the single-cycle CPU: the slave end of the `DM_CS`/`DM_R`/`DM_W`/`addr`/`wdata`/`rdata` interface driven by `top`. It holds the word-organised data storage and answers reads in the same cycle. CPU stores are posted into a small write buffer and drained into storage during cycles without a data access. A `dm_ready` stall output blocks a store when the buffer is full, and a sticky `err` flags illegal accesses.

## Interface
- `ADDR_W`, default 10: word-address bits; storage depth is 2^ADDR_W words.
- `WB_DEPTH`, default 4: write-buffer entries; power of two, ≥2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; asserted when 0.
- `DM_CS`  in  1: data access this cycle.
- `DM_R`  in  1: read strobe, qualified by `DM_CS`.
- `DM_W`  in  1: write strobe, qualified by `DM_CS`.
- `addr`  in  32: byte address; `addr[1:0]` must be 0.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data, combinational.
- `dm_ready`  out  1: 0 means the CPU must hold the current store and its PC.
- `err`  out  1: sticky illegal-access flag.

## Operation
- Legal access: `DM_CS`=1, exactly one of `DM_R` or `DM_W` set, `addr[1:0]`=0, and `addr[31:ADDR_W+2]`=0. Word index is `addr[ADDR_W+1:2]`.
- An illegal access sets `err` at the next edge. It has no effect on storage or the buffer, and `rdata`=0 while it is presented.
- Read:
  - `rdata` = youngest buffer entry whose index matches, else storage[index].
  - When `DM_CS`=0 or the access is not a read, `rdata`=0.
- Write:
  - Accepted at the edge when legal and `dm_ready`=1; pushed at the buffer tail.
  - No merging: two stores to the same word occupy two entries.
- `dm_ready` = !(`DM_CS` & `DM_W` & full). Reads never stall.
- Drain:
  - The head entry is written to storage at the edge when the buffer is non-empty and the array port is free.
  - The port is free when `DM_CS`=0, when the access is illegal, or when the current store is stalled (`dm_ready`=0). The last case prevents deadlock.
  - At most one drain per cycle.
- Push and drain in the same cycle: count unchanged, head and tail both advance.
- Pointers wrap modulo `WB_DEPTH`. Full = count==`WB_DEPTH`; empty = count==0. Count is $clog2(`WB_DEPTH`)+1 bits wide.
- Reset mid-operation: buffered, undrained stores are lost. Storage is not reset.

## Timing
- Reset values: `dm_ready`=1, `err`=0, `rdata`=0, buffer empty with count=0 and head=tail=0.
- Read latency is 0 cycles: `rdata` is valid in the same cycle and includes forwarded buffer data.
- A store accepted at edge N is visible to a read in cycle N+1 through forwarding. It reaches storage at the first free-port edge at or after N+1.
- A stalled store is accepted at the edge after the first drain. With a full buffer, `dm_ready` returns to 1 one cycle after the stall begins.
- `err` is set one edge after the illegal cycle and clears only by reset.

## Configuration
- `DM_WBUF_EN` defined: posted write buffer, forwarding and stall logic as above.
- `DM_WBUF_EN` undefined:
  - A legal store writes storage directly at the accepting edge.
  - `dm_ready` is tied to 1 and there is no buffer state.
  - Reads return storage[index] only.
  - `err` behaviour is unchanged.

## Structure
- The shared package `dm_pkg` holds:
  - the word-index and data width constants;
  - the write-buffer entry typedef {index, data};
  - the legality-check function.
- One sub-module, `dm_wbuf`: the FIFO with push/pop, full/empty and a parallel associative lookup returning the youngest hit. `dm_responder` owns the storage array, access decode, `err` and the port arbitration.

## Test plan
- Reset low mid-run with 3 stores buffered -> `dm_ready`=1, `err`=0, count=0; after release, a read of those words returns the prior storage contents.
- Store 0xDEADBEEF to 0x10, then immediately read 0x10 with `DM_CS` held -> `rdata`=0xDEADBEEF via forwarding. After one idle cycle, storage[4]=0xDEADBEEF.
- Stores 0x1 then 0x2 to 0x20 back-to-back, then read 0x20 -> `rdata`=0x2, the youngest entry. After draining, storage[8]=0x2.
- 5 consecutive stores with `WB_DEPTH`=4 -> `dm_ready`=0 on the 5th cycle. The 5th store is accepted the next cycle and the head is drained; no data is lost.
- Access to 0x13 (misaligned), to 0x1000 (out of range), and with `DM_R`=`DM_W`=1 -> `err`=1 after the first; storage and count unchanged; `rdata`=0.
- With `DM_WBUF_EN` undefined: store 0xA5A5A5A5 to 0x8 -> storage[2] is updated at that edge; `dm_ready` stays 1 throughout.
